rr_grant_encoder: RTL and testbench

//   Round-robin arbiter that picks one of numReq requesters and presents the winner as a

---
 rtl/rr_grant_encoder.sv | 104 ++++++++++
 tb/tb_rr_grant_encoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with binary grant index, held grants, and an optional hold timeout.
// The owner-done input is named grant_release because "release" is a reserved word.
module rr_grant_encoder #(
    parameter int inputLen = 3,
    parameter int numReq   = 1 << inputLen,
    parameter int MAX_HOLD = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [numReq-1:0]   req,
    input  logic                grant_release,
    output logic                grant_valid,
    output logic [inputLen-1:0] grant_idx,
    output logic                grant_expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [inputLen-1:0] PTR_RESET = inputLen'(numReq - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    // Only meaningful when MAX_HOLD != 0; the compare below is gated on that.
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t              state, state_next;
    logic [inputLen-1:0] last_ptr, ptr_next;
    logic [inputLen-1:0] idx_next, search_ptr, winner;
    logic [CNT_W-1:0]    hold_cnt, cnt_next;
    logic                valid_next, expired_next, found, timeout;

    // At the end of a grant the search restarts after the owner, so the owner is
    // naturally checked last and only wins again if it is the sole requester.
    assign search_ptr = (state == GRANT) ? grant_idx : last_ptr;
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        logic [inputLen-1:0] pos;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int i = 1; i <= numReq; i++) begin
            pos = inputLen'((int'(search_ptr) + i) % numReq);
            if (!found && req[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
    end

    always_comb begin
        state_next   = state;
        valid_next   = grant_valid;
        idx_next     = grant_idx;
        cnt_next     = hold_cnt;
        ptr_next     = last_ptr;
        expired_next = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    idx_next   = winner;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt != CNT_MAX) cnt_next = hold_cnt + 1'b1;
                if (grant_release || timeout) begin
                    ptr_next     = grant_idx;
                    expired_next = !grant_release;
                    cnt_next     = '0;
                    if (found) begin
                        idx_next = winner;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state         <= IDLE;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            grant_expired <= 1'b0;
            hold_cnt      <= '0;
            last_ptr      <= PTR_RESET;
        end else begin
            state         <= state_next;
            grant_valid   <= valid_next;
            grant_idx     <= idx_next;
            grant_expired <= expired_next;
            hold_cnt      <= cnt_next;
            last_ptr      <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: table of directed vectors on an untimed instance,
// plus hand-written timeout sequences on an instance with MAX_HOLD=4.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req0, req4;
    logic       rel0, rel4;
    logic       valid0, valid4, exp0, exp4;
    logic [2:0] idx0, idx4;

    always #5 clk = ~clk;

    rr_grant_encoder #(.inputLen(3), .numReq(8), .MAX_HOLD(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .grant_release(rel0),
        .grant_valid(valid0), .grant_idx(idx0), .grant_expired(exp0)
    );

    rr_grant_encoder #(.inputLen(3), .numReq(8), .MAX_HOLD(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .grant_release(rel4),
        .grant_valid(valid4), .grant_idx(idx4), .grant_expired(exp4)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic       v;
        logic [2:0] idx;
        logic       ex;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic [7:0] r, input logic rl,
                       input logic v, input logic [2:0] ix, input logic ex);
        vec_t t;
        t.rst = rst; t.req = r; t.rel = rl; t.v = v; t.idx = ix; t.ex = ex;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step4(input logic [7:0] r, input logic rl, input logic v,
                         input logic [2:0] ix, input logic ex, input string name);
        req4 = r;
        rel4 = rl;
        tick();
        check({name, " valid"},   8'(valid4), 8'(v));
        check({name, " idx"},     8'(idx4),   8'(ix));
        check({name, " expired"}, 8'(exp4),   8'(ex));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected it to end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0  = '0; rel0 = 1'b0;
        req4  = '0; rel4 = 1'b0;

        // Reset with no requests for five cycles.
        for (int i = 0; i < 5; i++) add(1, 8'h00, 0, 0, 3'd0, 0);
        // Fairness: 0 first (pointer starts at 7), then 7, then 0 again.
        add(0, 8'h81, 0, 1, 3'd0, 0);
        add(0, 8'h81, 1, 1, 3'd7, 0);
        add(0, 8'h81, 1, 1, 3'd0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 0);
        // Single-cycle request, grant held after req drops, release ends it.
        add(0, 8'h04, 0, 1, 3'd2, 0);
        for (int i = 0; i < 9; i++) add(0, 8'h00, 0, 1, 3'd2, 0);
        add(0, 8'h00, 1, 0, 3'd2, 0);
        add(0, 8'h00, 1, 0, 3'd2, 0);
        // Reset mid-grant drops the pending release and restores the pointer to 7.
        add(0, 8'h20, 0, 1, 3'd5, 0);
        add(1, 8'h21, 1, 0, 3'd0, 0);
        add(0, 8'h21, 0, 1, 3'd0, 0);
        add(0, 8'h21, 1, 1, 3'd5, 0);
        add(0, 8'h00, 1, 0, 3'd5, 0);
        add(1, 8'h00, 0, 0, 3'd0, 0);
        add(0, 8'h20, 0, 1, 3'd5, 0);
        // Sole requester re-wins after its own release with no bubble.
        add(0, 8'h20, 1, 1, 3'd5, 0);
        add(0, 8'h00, 1, 0, 3'd5, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            req0  = vecs[i].req;
            rel0  = vecs[i].rel;
            tick();
            check($sformatf("row%0d valid", i),   8'(valid0), 8'(vecs[i].v));
            check($sformatf("row%0d idx", i),     8'(idx0),   8'(vecs[i].idx));
            check($sformatf("row%0d expired", i), 8'(exp0),   8'(vecs[i].ex));
        end

        // Timeout instance: fresh reset.
        reset = 1'b1;
        step4(8'h00, 0, 0, 3'd0, 0, "t4 reset");
        reset = 1'b0;

        // Timeout hands over after four cycles, with a one-cycle expired pulse.
        step4(8'h0A, 0, 1, 3'd1, 0, "t4 c1");
        step4(8'h0A, 0, 1, 3'd1, 0, "t4 c2");
        step4(8'h0A, 0, 1, 3'd1, 0, "t4 c3");
        step4(8'h0A, 0, 1, 3'd1, 0, "t4 c4");
        step4(8'h0A, 0, 1, 3'd3, 1, "t4 expire");
        step4(8'h0A, 0, 1, 3'd3, 0, "t4 pulse end");
        step4(8'h0A, 0, 1, 3'd3, 0, "t4 hold2");
        step4(8'h0A, 0, 1, 3'd3, 0, "t4 hold3");
        // Timeout with nobody waiting drops to idle and still pulses expired.
        step4(8'h00, 0, 0, 3'd3, 1, "t4 expire idle");
        step4(8'h00, 0, 0, 3'd3, 0, "t4 idle");

        // Release coinciding with timeout counts as a release.
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 c1");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 c2");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 c3");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 c4");
        step4(8'h0A, 1, 1, 3'd3, 0, "t5 coincide");
        step4(8'h0A, 0, 1, 3'd3, 0, "t5 after");
        // Early release restarts the hold count for the next owner.
        step4(8'h0A, 1, 1, 3'd1, 0, "t5 early rel");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 r2");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 r3");
        step4(8'h0A, 0, 1, 3'd1, 0, "t5 r4");
        step4(8'h0A, 0, 1, 3'd3, 1, "t5 timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
